// File: rtl/ntlm_pkg.sv
// Shared widths and types for the NTLM cracker datapath: candidate packing,
// counter width and the candidate generator state encoding.
package ntlm_pkg;

    localparam int unsigned CAND_W    = 128;
    localparam int unsigned LEN_W     = 4;
    localparam int unsigned CNT_W     = 40;
    localparam int unsigned MAX_CHARS = CAND_W / 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} gen_state_t;

    // Candidate string with the first n characters set to ch and the rest zero.
    function automatic logic [0:CAND_W-1] fill_chars(input logic [LEN_W-1:0] n,
                                                     input logic [7:0]       ch);
        logic [0:CAND_W-1] s;
        s = '0;
        for (int unsigned i = 0; i < MAX_CHARS; i++) begin
            if (i < 32'(n)) s[8*i +: 8] = ch;
        end
        return s;
    endfunction

endpackage

// File: rtl/password_candidate_gen_if.sv
// Candidate handshake between the generator (master) and the hasher (slave).
interface password_candidate_gen_if;
    import ntlm_pkg::*;

    logic              cand_valid;
    logic              cand_ready;
    logic [0:CAND_W-1] cand_str;
    logic [0:LEN_W-1]  cand_len;

    modport master (output cand_valid, output cand_str, output cand_len, input  cand_ready);
    modport slave  (input  cand_valid, input  cand_str, input  cand_len, output cand_ready);

endinterface

// File: rtl/cand_odometer.sv
// Combinational successor of a candidate: odometer over CHAR_LO..CHAR_HI with the
// last character as least significant digit; a carry out of index 0 grows the length.
module cand_odometer
    import ntlm_pkg::*;
#(
    parameter int         MAX_LEN = 8,
    parameter logic [7:0] CHAR_LO = 8'h61,
    parameter logic [7:0] CHAR_HI = 8'h7a
) (
    input  logic [0:CAND_W-1] cur_str,
    input  logic [0:LEN_W-1]  cur_len,
    output logic [0:CAND_W-1] next_str,
    output logic [0:LEN_W-1]  next_len,
    output logic              last_flag
);

    logic       carry;
    logic       all_hi;
    logic [7:0] ch;

    always_comb begin
        next_str = cur_str;
        next_len = cur_len;
        carry    = 1'b1;
        all_hi   = 1'b1;
        ch       = '0;
        for (int i = MAX_LEN - 1; i >= 0; i--) begin
            if (i < int'(cur_len)) begin
                ch = cur_str[8*i +: 8];
                if (ch != CHAR_HI) all_hi = 1'b0;
                if (carry) begin
                    if (ch == CHAR_HI) begin
                        next_str[8*i +: 8] = CHAR_LO;
                    end else begin
                        next_str[8*i +: 8] = ch + 8'd1;
                        carry              = 1'b0;
                    end
                end
            end
        end
        if (carry) begin
            next_len = cur_len + LEN_W'(1);
            next_str = fill_chars(next_len, CHAR_LO);
        end
        last_flag = (cur_len == LEN_W'(MAX_LEN)) && all_hi;
    end

endmodule

// File: rtl/password_candidate_gen.sv
// Brute-force password candidate source: enumerates every string over a contiguous
// charset in length-then-lexicographic order, one candidate per accepted handshake.
module password_candidate_gen
    import ntlm_pkg::*;
#(
    parameter int         MIN_LEN = 1,
    parameter int         MAX_LEN = 8,
    parameter logic [7:0] CHAR_LO = 8'h61,
    parameter logic [7:0] CHAR_HI = 8'h7a
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    password_candidate_gen_if.master cand,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         cand_count
);

    localparam logic [0:CAND_W-1] INIT_STR = fill_chars(LEN_W'(MIN_LEN), CHAR_LO);

    gen_state_t        state;
    logic [0:CAND_W-1] next_str;
    logic [0:LEN_W-1]  next_len;
    logic              last_flag;

    cand_odometer #(
        .MAX_LEN (MAX_LEN),
        .CHAR_LO (CHAR_LO),
        .CHAR_HI (CHAR_HI)
    ) u_odometer (
        .cur_str   (cand.cand_str),
        .cur_len   (cand.cand_len),
        .next_str  (next_str),
        .next_len  (next_len),
        .last_flag (last_flag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cand.cand_valid <= 1'b0;
            cand.cand_str   <= '0;
            cand.cand_len   <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            cand_count      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (abort) begin
                        state           <= IDLE;
                        cand.cand_valid <= 1'b0;
                        busy            <= 1'b0;
                        done            <= 1'b0;
                    end else if (start) begin
                        state           <= RUN;
                        cand.cand_valid <= 1'b1;
                        cand.cand_str   <= INIT_STR;
                        cand.cand_len   <= LEN_W'(MIN_LEN);
                        busy            <= 1'b1;
                        done            <= 1'b0;
                        cand_count      <= '0;
                    end
                end
                RUN: begin
                    // valid is always high in RUN, so ready alone marks a transfer
                    if (cand.cand_ready) cand_count <= cand_count + CNT_W'(1);
                    if (abort) begin
                        state           <= IDLE;
                        cand.cand_valid <= 1'b0;
                        busy            <= 1'b0;
                        done            <= 1'b0;
                    end else if (cand.cand_ready) begin
                        if (last_flag) begin
                            state           <= DONE;
                            cand.cand_valid <= 1'b0;
                            busy            <= 1'b0;
                            done            <= 1'b1;
                        end else begin
                            cand.cand_str <= next_str;
                            cand.cand_len <= next_len;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
